// File: rtl/zap_wb_rr_arbiter.sv
// Two-master Wishbone B3 round-robin arbiter with a bus watchdog.
// Grants the shared bus to the instruction side (m0) or data side (m1) and routes responses to the owner only.

module zap_wb_rr_arbiter_chk (
  input logic i_clk,
  input logic i_reset,
  input logic i_wb_ack,
  input logic i_wb_err
);
  // A slave may only signal an error together with its acknowledge.
  err_needs_ack: assert property (@(posedge i_clk) disable iff (i_reset) !(i_wb_err && !i_wb_ack));
endmodule

module zap_wb_rr_arbiter #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd256
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_m0_wb_cyc_nxt,
  input  logic        i_m0_wb_stb_nxt,
  input  logic        i_m0_wb_wen_nxt,
  input  logic [3:0]  i_m0_wb_sel_nxt,
  input  logic [31:0] i_m0_wb_dat_nxt,
  input  logic [31:0] i_m0_wb_adr_nxt,
  input  logic [2:0]  i_m0_wb_cti_nxt,
  input  logic        i_m1_wb_cyc_nxt,
  input  logic        i_m1_wb_stb_nxt,
  input  logic        i_m1_wb_wen_nxt,
  input  logic [3:0]  i_m1_wb_sel_nxt,
  input  logic [31:0] i_m1_wb_dat_nxt,
  input  logic [31:0] i_m1_wb_adr_nxt,
  input  logic [2:0]  i_m1_wb_cti_nxt,
  output logic        o_m0_wb_ack,
  output logic        o_m0_wb_err,
  output logic [31:0] o_m0_wb_dat,
  output logic        o_m1_wb_ack,
  output logic        o_m1_wb_err,
  output logic [31:0] o_m1_wb_dat,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_wen,
  output logic [3:0]  o_wb_sel,
  output logic [31:0] o_wb_dat,
  output logic [31:0] o_wb_adr,
  output logic [2:0]  o_wb_cti,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  output logic [1:0]  o_owner,
  output logic        o_timeout
);
  localparam logic [2:0] CTI_EOB = 3'b111;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_M0   = 2'b01,
    OWN_M1   = 2'b10
  } owner_e;

  owner_e      owner_q, owner_d, win_s;
  logic        last_m1_q;
  logic [31:0] wd_q;
  logic        cyc_q, stb_q, wen_q;
  logic [3:0]  sel_q;
  logic [31:0] dat_q, adr_q;
  logic [2:0]  cti_q;
  logic        own_cyc_s, release_s, fire_s;

  // Ownership release, watchdog expiry and the round-robin pick for this cycle.
  always_comb begin
    own_cyc_s = 1'b0;
    win_s     = OWN_NONE;
    owner_d   = owner_q;
    case (owner_q)
      OWN_M0:  own_cyc_s = i_m0_wb_cyc_nxt;
      OWN_M1:  own_cyc_s = i_m1_wb_cyc_nxt;
      default: own_cyc_s = 1'b0;
    endcase
    fire_s    = (TIMEOUT_CYCLES != 32'd0) && stb_q && !i_wb_ack && (wd_q == TIMEOUT_CYCLES - 32'd1);
    // An idle owner slot also counts as released, since stb is always low then.
    release_s = !own_cyc_s && (!stb_q || i_wb_ack);
    case ({i_m1_wb_cyc_nxt, i_m0_wb_cyc_nxt})
      2'b01:   win_s = OWN_M0;
      2'b10:   win_s = OWN_M1;
      2'b11: begin
        if (last_m1_q) win_s = OWN_M0;
        else           win_s = OWN_M1;
      end
      default: win_s = OWN_NONE;
    endcase
    if (fire_s)         owner_d = OWN_NONE;
    else if (release_s) owner_d = win_s;
    else                owner_d = owner_q;
  end

  // Owner state, grant history, watchdog and the registered external bus.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      owner_q   <= OWN_NONE;
      last_m1_q <= 1'b1;
      wd_q      <= 32'd0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      wen_q     <= 1'b0;
      sel_q     <= 4'd0;
      dat_q     <= 32'd0;
      adr_q     <= 32'd0;
      cti_q     <= CTI_EOB;
    end else begin
      owner_q <= owner_d;
      if (fire_s) begin
        // Abandon the hung cycle; the bus idles one cycle before the next grant.
        last_m1_q <= (owner_q == OWN_M1);
        wd_q      <= 32'd0;
        cyc_q     <= 1'b0;
        stb_q     <= 1'b0;
        cti_q     <= CTI_EOB;
      end else begin
        if (release_s && (win_s != OWN_NONE)) last_m1_q <= (win_s == OWN_M1);
        wd_q <= (stb_q && !i_wb_ack) ? wd_q + 32'd1 : 32'd0;
        case (owner_d)
          OWN_M0: begin
            cyc_q <= i_m0_wb_cyc_nxt;
            stb_q <= i_m0_wb_stb_nxt;
            wen_q <= i_m0_wb_wen_nxt;
            sel_q <= i_m0_wb_sel_nxt;
            dat_q <= i_m0_wb_dat_nxt;
            adr_q <= i_m0_wb_adr_nxt;
            cti_q <= i_m0_wb_cti_nxt;
          end
          OWN_M1: begin
            cyc_q <= i_m1_wb_cyc_nxt;
            stb_q <= i_m1_wb_stb_nxt;
            wen_q <= i_m1_wb_wen_nxt;
            sel_q <= i_m1_wb_sel_nxt;
            dat_q <= i_m1_wb_dat_nxt;
            adr_q <= i_m1_wb_adr_nxt;
            cti_q <= i_m1_wb_cti_nxt;
          end
          default: begin
            cyc_q <= 1'b0;
            stb_q <= 1'b0;
            cti_q <= CTI_EOB;
          end
        endcase
      end
    end
  end

  assign o_wb_cyc  = cyc_q;
  assign o_wb_stb  = stb_q;
  assign o_wb_wen  = wen_q;
  assign o_wb_sel  = sel_q;
  assign o_wb_dat  = dat_q;
  assign o_wb_adr  = adr_q;
  assign o_wb_cti  = cti_q;
  assign o_owner   = owner_q;
  assign o_timeout = fire_s;

  assign o_m0_wb_ack = (owner_q == OWN_M0) && (i_wb_ack || fire_s);
  assign o_m0_wb_err = (owner_q == OWN_M0) && (i_wb_err || fire_s);
  assign o_m0_wb_dat = (owner_q == OWN_M0) ? i_wb_dat : 32'd0;
  assign o_m1_wb_ack = (owner_q == OWN_M1) && (i_wb_ack || fire_s);
  assign o_m1_wb_err = (owner_q == OWN_M1) && (i_wb_err || fire_s);
  assign o_m1_wb_dat = (owner_q == OWN_M1) ? i_wb_dat : 32'd0;

  zap_wb_rr_arbiter_chk u_chk (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_wb_ack (i_wb_ack),
    .i_wb_err (i_wb_err)
  );
endmodule

// File: tb/tb_zap_wb_rr_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural model of ownership, round-robin choice and the watchdog.

module tb_zap_wb_rr_arbiter;
  localparam int TMO = 4;

  logic        clk;
  logic        i_reset;
  logic        in_cyc[2], in_stb[2], in_wen[2];
  logic [3:0]  in_sel[2];
  logic [31:0] in_dat[2], in_adr[2];
  logic [2:0]  in_cti[2];
  logic        s_ack, s_err;
  logic [31:0] s_dat;

  logic        o_ack[2], o_err[2];
  logic [31:0] o_mdat[2];
  logic        o_wb_cyc, o_wb_stb, o_wb_wen;
  logic [3:0]  o_wb_sel;
  logic [31:0] o_wb_dat, o_wb_adr;
  logic [2:0]  o_wb_cti;
  logic [1:0]  o_owner;
  logic        o_timeout;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: owner as master index (-1 = nobody), last granted index, stall count, bus image.
  int          m_own, m_last, m_wd;
  logic        m_cyc, m_stb, m_wen;
  logic [3:0]  m_sel;
  logic [31:0] m_dat, m_adr;
  logic [2:0]  m_cti;

  zap_wb_rr_arbiter #(.TIMEOUT_CYCLES(32'd4)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_m0_wb_cyc_nxt(in_cyc[0]), .i_m0_wb_stb_nxt(in_stb[0]), .i_m0_wb_wen_nxt(in_wen[0]),
    .i_m0_wb_sel_nxt(in_sel[0]), .i_m0_wb_dat_nxt(in_dat[0]), .i_m0_wb_adr_nxt(in_adr[0]),
    .i_m0_wb_cti_nxt(in_cti[0]),
    .i_m1_wb_cyc_nxt(in_cyc[1]), .i_m1_wb_stb_nxt(in_stb[1]), .i_m1_wb_wen_nxt(in_wen[1]),
    .i_m1_wb_sel_nxt(in_sel[1]), .i_m1_wb_dat_nxt(in_dat[1]), .i_m1_wb_adr_nxt(in_adr[1]),
    .i_m1_wb_cti_nxt(in_cti[1]),
    .o_m0_wb_ack(o_ack[0]), .o_m0_wb_err(o_err[0]), .o_m0_wb_dat(o_mdat[0]),
    .o_m1_wb_ack(o_ack[1]), .o_m1_wb_err(o_err[1]), .o_m1_wb_dat(o_mdat[1]),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_wen(o_wb_wen), .o_wb_sel(o_wb_sel),
    .o_wb_dat(o_wb_dat), .o_wb_adr(o_wb_adr), .o_wb_cti(o_wb_cti),
    .i_wb_dat(s_dat), .i_wb_ack(s_ack), .i_wb_err(s_err),
    .o_owner(o_owner), .o_timeout(o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit model_fires();
    return (TMO != 0) && m_stb && !s_ack && (m_wd == TMO - 1);
  endfunction

  task automatic check_all();
    bit          f;
    logic [1:0]  eo;
    f  = model_fires();
    eo = (m_own < 0) ? 2'b00 : ((m_own == 0) ? 2'b01 : 2'b10);
    check_eq("owner", 32'(o_owner), 32'(eo));
    check_eq("cyc", 32'(o_wb_cyc), 32'(m_cyc));
    check_eq("stb", 32'(o_wb_stb), 32'(m_stb));
    check_eq("wen", 32'(o_wb_wen), 32'(m_wen));
    check_eq("sel", 32'(o_wb_sel), 32'(m_sel));
    check_eq("wdat", o_wb_dat, m_dat);
    check_eq("adr", o_wb_adr, m_adr);
    check_eq("cti", 32'(o_wb_cti), 32'(m_cti));
    check_eq("timeout", 32'(o_timeout), 32'(f));
    for (int n = 0; n < 2; n++) begin
      check_eq($sformatf("ack%0d", n), 32'(o_ack[n]), 32'((m_own == n) && (s_ack || f)));
      check_eq($sformatf("err%0d", n), 32'(o_err[n]), 32'((m_own == n) && (s_err || f)));
      check_eq($sformatf("rdat%0d", n), o_mdat[n], (m_own == n) ? s_dat : 32'd0);
    end
  endtask

  task automatic model_update();
    bit f;
    bit free;
    int win;
    f = model_fires();
    if (i_reset) begin
      m_own = -1; m_last = 1; m_wd = 0;
      m_cyc = 1'b0; m_stb = 1'b0; m_wen = 1'b0;
      m_sel = 4'd0; m_dat = 32'd0; m_adr = 32'd0; m_cti = 3'b111;
    end else if (f) begin
      m_last = m_own; m_own = -1; m_wd = 0;
      m_cyc = 1'b0; m_stb = 1'b0; m_cti = 3'b111;
    end else begin
      m_wd = (m_stb && !s_ack) ? m_wd + 1 : 0;
      free = (m_own < 0) || (!in_cyc[m_own] && (!m_stb || s_ack));
      if (free) begin
        if (in_cyc[0] && in_cyc[1]) win = 1 - m_last;
        else if (in_cyc[0])         win = 0;
        else if (in_cyc[1])         win = 1;
        else                        win = -1;
        if (win >= 0) m_last = win;
        m_own = win;
      end
      if (m_own >= 0) begin
        m_cyc = in_cyc[m_own]; m_stb = in_stb[m_own]; m_wen = in_wen[m_own];
        m_sel = in_sel[m_own]; m_dat = in_dat[m_own]; m_adr = in_adr[m_own];
        m_cti = in_cti[m_own];
      end else begin
        m_cyc = 1'b0; m_stb = 1'b0; m_cti = 3'b111;
      end
    end
  endtask

  task automatic step();
    #2;
    check_all();
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic drv(input int m, input bit cyc, input bit stb, input bit wen,
                     input logic [31:0] adr, input logic [2:0] cti);
    in_cyc[m] = cyc; in_stb[m] = stb; in_wen[m] = wen;
    in_adr[m] = adr; in_cti[m] = cti; in_sel[m] = 4'hF;
    in_dat[m] = adr ^ 32'h5A5A_0000;
  endtask

  task automatic slv(input bit ack, input bit err, input logic [31:0] dat);
    s_ack = ack; s_err = err; s_dat = dat;
  endtask

  task automatic idle_all();
    drv(0, 1'b0, 1'b0, 1'b0, 32'd0, 3'b111);
    drv(1, 1'b0, 1'b0, 1'b0, 32'd0, 3'b111);
    slv(1'b0, 1'b0, 32'd0);
  endtask

  task automatic do_reset();
    idle_all();
    i_reset = 1'b1;
    step();
    step();
    i_reset = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1;
    idle_all();
    repeat (2) begin
      @(posedge clk);
      #1;
      model_update();
    end
    i_reset = 1'b0;
    #1;
    check_eq("rst_cyc", 32'(o_wb_cyc), 32'd0);
    check_eq("rst_cti", 32'(o_wb_cti), 32'd7);
    check_eq("rst_owner", 32'(o_owner), 32'd0);
    step();

    // Single m0 read.
    drv(0, 1'b1, 1'b1, 1'b0, 32'h0000_1000, 3'b111);
    step();
    #1;
    check_eq("a_adr", o_wb_adr, 32'h0000_1000);
    check_eq("a_owner", 32'(o_owner), 32'd1);
    drv(0, 1'b0, 1'b0, 1'b0, 32'h0000_1000, 3'b111);
    slv(1'b1, 1'b0, 32'hDEAD_BEEF);
    #1;
    check_eq("a_ack0", 32'(o_ack[0]), 32'd1);
    check_eq("a_dat0", o_mdat[0], 32'hDEAD_BEEF);
    check_eq("a_ack1", 32'(o_ack[1]), 32'd0);
    step();
    slv(1'b0, 1'b0, 32'd0);
    step();

    // Contention and alternation.
    do_reset();
    drv(0, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 3'b111);
    drv(1, 1'b1, 1'b1, 1'b0, 32'h0000_0200, 3'b111);
    step();
    #1;
    check_eq("b_first", 32'(o_owner), 32'd1);
    slv(1'b1, 1'b0, 32'd1);
    drv(0, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 3'b111);
    step();
    #1;
    check_eq("b_second", 32'(o_owner), 32'd2);
    drv(1, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 3'b111);
    step();
    slv(1'b0, 1'b0, 32'd0);
    drv(0, 1'b1, 1'b1, 1'b0, 32'h0000_0104, 3'b111);
    drv(1, 1'b1, 1'b1, 1'b0, 32'h0000_0204, 3'b111);
    step();
    #1;
    check_eq("b_third", 32'(o_owner), 32'd1);
    idle_all();
    step();

    // m1 incrementing burst is not preempted by m0.
    do_reset();
    drv(1, 1'b1, 1'b1, 1'b0, 32'h0000_2000, 3'b010);
    step();
    for (int b = 0; b < 4; b++) begin
      #1;
      check_eq($sformatf("c_own%0d", b), 32'(o_owner), 32'd2);
      slv(1'b1, 1'b0, 32'(b));
      drv(0, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 3'b111);
      if (b < 3) drv(1, 1'b1, 1'b1, 1'b0, 32'h0000_2000 + 32'(4 * (b + 1)), (b == 2) ? 3'b111 : 3'b010);
      else       drv(1, 1'b0, 1'b0, 1'b0, 32'h0000_2000, 3'b111);
      step();
    end
    #1;
    check_eq("c_m0", 32'(o_owner), 32'd1);
    idle_all();
    step();

    // Watchdog fires on the fourth unacknowledged strobe cycle.
    do_reset();
    drv(0, 1'b1, 1'b1, 1'b0, 32'h0000_4000, 3'b111);
    step();
    repeat (3) step();
    #1;
    check_eq("d_ack0", 32'(o_ack[0]), 32'd1);
    check_eq("d_err0", 32'(o_err[0]), 32'd1);
    check_eq("d_tmo", 32'(o_timeout), 32'd1);
    step();
    #1;
    check_eq("d_cyc", 32'(o_wb_cyc), 32'd0);
    check_eq("d_owner", 32'(o_owner), 32'd0);
    idle_all();
    step();

    // A real ACK in the would-be timeout cycle is a normal completion.
    do_reset();
    drv(0, 1'b1, 1'b1, 1'b0, 32'h0000_4000, 3'b111);
    step();
    repeat (3) step();
    slv(1'b1, 1'b0, 32'h1234_5678);
    drv(0, 1'b0, 1'b0, 1'b0, 32'h0000_4000, 3'b111);
    #1;
    check_eq("e_tmo", 32'(o_timeout), 32'd0);
    check_eq("e_ack0", 32'(o_ack[0]), 32'd1);
    check_eq("e_err0", 32'(o_err[0]), 32'd0);
    step();
    idle_all();
    step();

    // Slave error on an m1 write.
    do_reset();
    drv(1, 1'b1, 1'b1, 1'b1, 32'h0000_3000, 3'b111);
    step();
    drv(1, 1'b0, 1'b0, 1'b0, 32'h0000_3000, 3'b111);
    slv(1'b1, 1'b1, 32'd0);
    #1;
    check_eq("f_err1", 32'(o_err[1]), 32'd1);
    check_eq("f_err0", 32'(o_err[0]), 32'd0);
    step();
    idle_all();
    step();

    // Reset in the middle of an m1 burst.
    do_reset();
    drv(1, 1'b1, 1'b1, 1'b0, 32'h0000_5000, 3'b010);
    step();
    slv(1'b1, 1'b0, 32'd0);
    drv(1, 1'b1, 1'b1, 1'b0, 32'h0000_5004, 3'b010);
    step();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    #1;
    check_eq("g_cyc", 32'(o_wb_cyc), 32'd0);
    check_eq("g_cti", 32'(o_wb_cti), 32'd7);
    check_eq("g_owner", 32'(o_owner), 32'd0);
    slv(1'b0, 1'b0, 32'd0);
    drv(0, 1'b1, 1'b1, 1'b0, 32'h0000_0300, 3'b111);
    drv(1, 1'b1, 1'b1, 1'b0, 32'h0000_5008, 3'b010);
    step();
    #1;
    check_eq("g_first", 32'(o_owner), 32'd1);
    idle_all();
    step();

    // Randomized traffic.
    do_reset();
    for (int cyc_i = 0; cyc_i < 3000; cyc_i++) begin
      for (int m = 0; m < 2; m++) begin
        if (in_cyc[m]) in_cyc[m] = ($urandom_range(7) != 0);
        else           in_cyc[m] = ($urandom_range(1) == 1);
        in_stb[m] = in_cyc[m] && ($urandom_range(3) != 0);
        in_wen[m] = $urandom_range(1) == 1;
        in_sel[m] = 4'($urandom_range(15));
        in_dat[m] = $urandom;
        in_adr[m] = $urandom;
        in_cti[m] = ($urandom_range(1) == 1) ? 3'b010 : 3'b111;
      end
      s_ack   = o_wb_stb && ($urandom_range(2) == 0);
      s_err   = s_ack && ($urandom_range(3) == 0);
      s_dat   = $urandom;
      i_reset = ($urandom_range(499) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
